mc_cpu_core: RTL
================

Name: mc_cpu_core

Overview:
Second-generation multicycle MIPS-subset CPU core for the ZPC system.
- Reset and interrupt vectors are parametrised.
- Memory access uses a request/ready handshake with any number of wait states.
- Exceptions are precise, with EPC save and eret return.
- Connects to the memory/bus controller through separate read and write data paths; the system top adapts these to the shared tri-state bus.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
INT_VECTOR, 32'h0000_00D8, handler address taken on an accepted interrupt
INT_EN_RST, 1, reset value of the interrupt-enable flag

Ports:
clk  in  1  CPU clock, all state changes on rising edge
rst  in  1  asynchronous active-high reset
mem_addr  out  32  byte address of the current access
mem_rd  out  1  read request, held until ready
mem_wr  out  2  write request: 0 none, 1 word, 3 byte (2 reserved, never driven)
mem_wdata  out  32  store data; byte stores place the byte in [7:0]
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  access completes on the rising edge where it is high with mem_rd or mem_wr≠0
int_req  in  1  level-sensitive interrupt request
int_ack  out  1  one-cycle pulse when an interrupt is taken
epc  out  32  current EPC register, for debug and handler use

Behaviour:
Reset: PC=RESET_PC; all 32 GPRs=0; IR=0; EPC=0; int_en=INT_EN_RST; state=FETCH. mem_addr, mem_wdata=0; mem_rd=0; mem_wr=0; int_ack=0. Reset is effective mid-access with no completion; the memory side must drop the transaction.

FSM states:
- FETCH: mem_addr=PC, mem_rd=1. When mem_ready=1: IR<=mem_rdata, PC<=PC+4, go to DECODE. Otherwise hold all outputs stable.
- DECODE: RA<=GPR[rs], RB<=GPR[rt], Dst selected (rt for I-type, rd for R-type, 31 for jal).
- EXEC: ALU computes. Next state depends on the instruction class:
  - beq/bne: if taken, PC<=PC+(sext(imm)<<2); go to FETCH.
  - j/jal: PC<={PC[31:28],target,2'b00}; jal goes to WB to write the link PC, j goes to FETCH.
  - jr: PC<=RA; go to FETCH.
  - eret: PC<=EPC, int_en<=1; go to FETCH.
  - loads/stores: go to MEM.
  - all others: go to WB.
- MEM: mem_addr=RA+sext(imm). Loads assert mem_rd; sw drives mem_wr=1, sb drives mem_wr=3, mem_wdata=RB. Hold until mem_ready. Loads go to WB with data latched; stores go to FETCH.
- WB: GPR[Dst]<=result. Writes to GPR[0] are discarded, so reads of $0 always return 0. Go to FETCH.

Latency with mem_ready tied high:
- branch/jump/jr/eret: 3 cycles
- ALU/jal: 4 cycles
- store: 4 cycles
- load: 5 cycles

Each wait cycle adds one cycle.

ISA:
- R-type: add, addu, sub, subu, and, or, xor, nor, slt (signed), sltu, sll, srl, sra (shamt), jr.
- I-type: addi, addiu, andi, ori, xori (zero-extended imm), lui, slti, sltiu, lw, sw, lbu (zero-extended, byte lane by addr[1:0], little-endian), sb, beq, bne.
- J-type: j, jal.
- Other: eret (op 0x10, func 0x18).

Arithmetic: all arithmetic is 32-bit wraparound; no overflow trap.

Unknown opcode: executes as NOP and returns to FETCH after EXEC.

Interrupts:
- Sampled only at the instruction boundary, i.e. on the transition into FETCH.
- If int_req && int_en: EPC<=next PC (the PC the FSM would fetch), PC<=INT_VECTOR, int_en<=0, int_ack=1 for that cycle.
- An interrupt is never taken mid-instruction or during memory wait states.
- eret followed by still-high int_req: the interrupt is taken again at the next boundary.

Optional Feature:
Macro CPU_TRACE_EN.
- With it defined: adds ports trace_valid (out 1), trace_pc (out 32) and trace_ir (out 32). trace_valid pulses for one cycle at each instruction retire, including NOPs and taken interrupts' preempted boundary excluded. trace_pc holds that instruction's address; trace_ir holds its encoding. Ports reset to 0.
- Without it: the ports do not exist and there is no trace logic.

Test Plan:
- Reset, mem_ready=1, program addi $1,$0,5; addi $2,$1,-7 -> $1=5, $2=32'hFFFF_FFFE; the first fetch address equals RESET_PC.
- sw $2,0x10($0), then lbu $3,0x10($0), then lbu $4,0x11($0) -> mem_wr=1 with data FFFF_FFFE; $3=0xFE, $4=0xFF; sb drives mem_wr=3.
- Insert 3 wait cycles on every access -> mem_addr/mem_rd stay stable while ready=0; results identical; ALU instruction takes 7 cycles.
- beq $0,$0,-1 self-loop, int_req=1 -> int_ack pulse at the boundary, EPC = loop address, PC=0xD8; a second int_req is ignored until eret; eret returns to the loop.
- Assert rst during a MEM wait with mem_wr=1 -> mem_wr drops to 0 immediately; PC=RESET_PC; GPRs=0.
- jal to 0x40, then jr $31 -> $31=jal_addr+4; execution resumes at jal_addr+4; a write to $0 leaves it reading 0.

Source files
------------

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multicycle MIPS-subset CPU core.
// One instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB]. Every memory
// access is a request held stable until mem_ready. Interrupts are taken only
// when an instruction retires and the FSM re-enters FETCH.
// The memory-side outputs are registered, so an asynchronous reset clears them
// at once. The first FETCH cycle after reset only issues the request.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   mem_addr/rd/wr/wdata  access request (mem_wr: 0 none, 1 word, 3 byte)
//   mem_rdata, mem_ready  read data and access completion
//   int_req, int_ack      level interrupt request, one-cycle accept pulse
//   epc                   exception return address
// Optional macro CPU_TRACE_EN adds trace_valid/trace_pc/trace_ir, a retire trace.
module mc_cpu_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_00D8,
  parameter bit          INT_EN_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [1:0]  mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        int_req,
  output logic        int_ack,
  output logic [31:0] epc
`ifdef CPU_TRACE_EN
  ,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_ir
`endif
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                         OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_COP0 = 6'h10, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_SB = 6'h28, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08,
                         F_ERET = 6'h18, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                         F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  state_t             state, state_nx;
  logic [31:0]        pc, pc_nx, ir, res, mdr, alu_res;
  logic signed [31:0] ra, rb, simm;
  logic [31:0]        zimm, jtarget;
  logic [31:0]        gpr [32];
  logic [4:0]         dst;
  logic               int_en, is_alu, go_fetch, take_int;

  wire [5:0] op    = ir[31:26];
  wire [5:0] funct = ir[5:0];
  wire [4:0] shamt = ir[10:6];

  wire is_beq   = (op == OP_BEQ);
  wire is_bne   = (op == OP_BNE);
  wire is_j     = (op == OP_J);
  wire is_jal   = (op == OP_JAL);
  wire is_jr    = (op == OP_R) && (funct == F_JR);
  wire is_eret  = (op == OP_COP0) && (funct == F_ERET);
  wire is_lbu   = (op == OP_LBU);
  wire is_load  = (op == OP_LW) || is_lbu;
  wire is_sw    = (op == OP_SW);
  wire is_sb    = (op == OP_SB);
  wire is_store = is_sw || is_sb;

  assign simm    = $signed({{16{ir[15]}}, ir[15:0]});
  assign zimm    = {16'd0, ir[15:0]};
  assign jtarget = {pc[31:28], ir[25:0], 2'b00};

  // Little-endian byte lane select for lbu.
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

  always_comb begin
    alu_res = '0;
    is_alu  = 1'b1;
    if (op == OP_R) begin
      case (funct)
        F_ADD, F_ADDU: alu_res = ra + rb;
        F_SUB, F_SUBU: alu_res = ra - rb;
        F_AND:         alu_res = ra & rb;
        F_OR:          alu_res = ra | rb;
        F_XOR:         alu_res = ra ^ rb;
        F_NOR:         alu_res = ~(ra | rb);
        F_SLT:         alu_res = {31'd0, ra < rb};
        F_SLTU:        alu_res = {31'd0, $unsigned(ra) < $unsigned(rb)};
        F_SLL:         alu_res = rb << shamt;
        F_SRL:         alu_res = rb >> shamt;
        F_SRA:         alu_res = rb >>> shamt;
        default:       is_alu  = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_ADDIU: alu_res = ra + simm;
        OP_SLTI:           alu_res = {31'd0, ra < simm};
        OP_SLTIU:          alu_res = {31'd0, $unsigned(ra) < $unsigned(simm)};
        OP_ANDI:           alu_res = ra & zimm;
        OP_ORI:            alu_res = ra | zimm;
        OP_XORI:           alu_res = ra ^ zimm;
        OP_LUI:            alu_res = {ir[15:0], 16'd0};
        default:           is_alu  = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      S_FETCH:  if (mem_rd && mem_ready) begin
                  state_nx = S_DECODE;
                  pc_nx    = pc + 32'd4;
                end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        // pc already points past this instruction, so branches are pc-relative to it.
        state_nx = S_FETCH;
        if (is_beq || is_bne) begin
          if ((ra == rb) == is_beq) pc_nx = pc + {simm[29:0], 2'b00};
        end else if (is_j) begin
          pc_nx = jtarget;
        end else if (is_jal) begin
          pc_nx    = jtarget;
          state_nx = S_WB;
        end else if (is_jr) begin
          pc_nx = ra;
        end else if (is_eret) begin
          pc_nx = epc;
        end else if (is_load || is_store) begin
          state_nx = S_MEM;
        end else if (is_alu) begin
          state_nx = S_WB;
        end
      end
      S_MEM:    if (mem_ready) state_nx = is_load ? S_WB : S_FETCH;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Instruction boundary: the only point where an interrupt may preempt.
  assign go_fetch = (state != S_FETCH) && (state_nx == S_FETCH);
  assign take_int = go_fetch && int_req && int_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      epc       <= '0;
      int_en    <= INT_EN_RST;
      int_ack   <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      dst       <= '0;
      res       <= '0;
      mdr       <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 2'd0;
      mem_wdata <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      int_ack <= 1'b0;
      pc      <= pc_nx;
      case (state)
        // FETCH: a request is only missing here right after reset.
        S_FETCH: begin
          if (!mem_rd) begin
            mem_rd   <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir     <= mem_rdata;
            mem_rd <= 1'b0;
          end
        end
        // DECODE: operand fetch and destination select.
        S_DECODE: begin
          ra  <= $signed(gpr[ir[25:21]]);
          rb  <= $signed(gpr[ir[20:16]]);
          dst <= is_jal ? 5'd31 : ((op == OP_R) ? ir[15:11] : ir[20:16]);
        end
        // EXEC: latch result (link address for jal) and launch data access.
        S_EXEC: begin
          res <= is_jal ? pc : alu_res;
          if (is_eret) int_en <= 1'b1;
          if (is_load || is_store) begin
            mem_addr  <= ra + simm;
            mem_rd    <= is_load;
            mem_wr    <= is_sw ? 2'd1 : (is_sb ? 2'd3 : 2'd0);
            mem_wdata <= rb;
          end
        end
        // MEM: hold the request until ready, then capture load data.
        S_MEM: begin
          if (mem_ready) begin
            mem_rd <= 1'b0;
            mem_wr <= 2'd0;
            mdr    <= is_lbu ? {24'd0, byte_lane(mem_rdata, mem_addr[1:0])} : mem_rdata;
          end
        end
        // WB: register $0 is never written so it always reads zero.
        S_WB: begin
          if (dst != 5'd0) gpr[dst] <= is_load ? mdr : res;
        end
        default: ;
      endcase
      if (go_fetch) begin
        mem_rd   <= 1'b1;
        mem_addr <= take_int ? INT_VECTOR : pc_nx;
        if (take_int) begin
          epc     <= pc_nx;
          pc      <= INT_VECTOR;
          int_en  <= 1'b0;
          int_ack <= 1'b1;
        end
      end
    end
  end

`ifdef CPU_TRACE_EN
  logic [31:0] ipc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ipc         <= '0;
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_ir    <= '0;
    end else begin
      trace_valid <= go_fetch;
      if ((state == S_FETCH) && mem_rd && mem_ready) ipc <= pc;
      if (go_fetch) begin
        trace_pc <= ipc;
        trace_ir <= ir;
      end
    end
  end
`endif

endmodule
